intr_arb: RTL and testbench
===========================

INTR_ARB -- requirements
Module: intr_arb

Interface
REQ-001 Parameter NREQ, default 4, number of interrupting devices; index 0 is highest priority.
REQ-002 Parameter DESKEW, default 2, cycles bg_in_h must stay high before it is accepted.
REQ-003 Parameter TMO, default 255, maximum cycles to wait for ssyn_in_h during vector transfer.
REQ-004 CLOCK  input  1  the single clock; all state changes on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 irq_in  input  NREQ  level interrupt requests from devices, for example the intreq output of a teletype interface.
REQ-007 vec_in  input  8*NREQ  per-device vector; device i occupies bits [8i+7:8i].
REQ-008 irq_ack  output  NREQ  one-cycle pulse to the device whose vector was accepted.
REQ-009 init_in_h  input  1  bus INIT, synchronous abort.
REQ-010 bg_in_h / bbsy_in_h / ssyn_in_h  input  1 each  bus grant in, bus busy, slave sync.
REQ-011 br_out_h / sack_out_h / bbsy_out_h / intr_out_h  output  1 each  bus request, select acknowledge, bus busy, interrupt strobe.
REQ-012 bg_out_h  output  1  grant passed to the next device in the chain (combinational).
REQ-013 d_out_h  output  16  vector onto the data lines; bits [15:8] are always 0.
REQ-014 timeout_out  output  1  one-cycle pulse when a vector transfer times out.

Function
REQ-015 The block SHALL use states IDLE, REQ, DESK, SACK, INTR and REL, with all outputs except bg_out_h registered.
REQ-016 IDLE: all outputs 0; when any irq_in bit is set and bg_in_h=0, go to REQ.
REQ-017 IDLE with bg_in_h=1 SHALL stay in IDLE, because that grant belongs to a downstream device.
REQ-018 bg_out_h SHALL equal bg_in_h in IDLE and be 0 in every other state.
REQ-019 REQ: br_out_h=1.
- No irq_in bit set: go to IDLE, with br_out_h 0 in the next cycle.
- bg_in_h=1: latch the lowest set irq_in index and its vector, clear the deskew counter, go to DESK.
REQ-020 DESK: br_out_h=1; the counter increments each cycle.
- bg_in_h drops before the counter reaches DESKEW: return to REQ and discard the latch.
- Counter reaches DESKEW with bg_in_h still 1: go to SACK.
REQ-021 SACK: sack_out_h=1, br_out_h=0; go to INTR when bg_in_h, bbsy_in_h and ssyn_in_h are all 0 in the same cycle.
REQ-022 INTR: bbsy_out_h=1, intr_out_h=1, sack_out_h=0, d_out_h={8'b0, latched vector}; the timeout counter starts at 0.
REQ-023 INTR with ssyn_in_h=1: pulse irq_ack on the latched index for exactly one cycle, then go to REL.
REQ-024 INTR where the counter reaches TMO without ssyn_in_h: pulse timeout_out, no irq_ack, go to REL.
REQ-025 REL: all bus outputs 0 and d_out_h=0; go to IDLE once ssyn_in_h=0.
REQ-026 The winner is fixed when grant is taken; a higher-priority irq_in asserted after that waits for the next arbitration.
REQ-027 A latched device dropping irq_in after the REQ exit SHALL NOT abort the sequence; its latched vector is still delivered.
REQ-028 Counters SHALL be wide enough for DESKEW and TMO without wrap; the timeout counter saturates.
REQ-029 init_in_h=1 in any state SHALL, on the next edge, force IDLE, zero all registered outputs and cancel any pending ack or timeout pulse.

Reset
REQ-030 RESET high SHALL immediately force IDLE, with all outputs 0, counters 0 and latch 0, regardless of CLOCK.
REQ-031 Reset asserted mid-transfer (INTR) SHALL drop intr_out_h and bbsy_out_h asynchronously and emit no irq_ack.

Verification
REQ-032 irq_in=4'b0100, vec_in[23:16]=8'o064; raise bg for 3 cycles -> DESK then SACK; then bus idle -> d_out_h=16'o000064 with intr_out_h; ssyn -> irq_ack=4'b0100 for one cycle.
REQ-033 irq_in=4'b1010 -> the granted vector is the one from index 1; irq_ack=4'b0010.
REQ-034 bg_in_h pulses high 1 cycle in DESK -> return to REQ, br_out_h stays 1, no sack_out_h.
REQ-035 bg_in_h=1 while in IDLE with irq_in=0 -> bg_out_h=1 in the same cycle; with irq_in=0001 and bg already high -> remain IDLE, bg_out_h=1.
REQ-036 INTR with no ssyn for 255 cycles -> timeout_out pulse, irq_ack=0, REL then IDLE.
REQ-037 RESET asserted during INTR -> intr_out_h=0 before the next clock edge; init_in_h during SACK -> IDLE the next cycle.

Source files
------------

// File: rtl/intr_arb.sv
// Bus interrupt arbiter: request, deskew, select-ack, vector strobe, release.
// States IDLE -> REQ -> DESK -> SACK -> INTR -> REL; init_in_h aborts any state to IDLE.
module intr_arb #(
  parameter int NREQ   = 4,
  parameter int DESKEW = 2,
  parameter int TMO    = 255
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [NREQ-1:0]   irq_in,
  input  logic [8*NREQ-1:0] vec_in,
  output logic [NREQ-1:0]   irq_ack,
  input  logic              init_in_h,
  input  logic              bg_in_h,
  input  logic              bbsy_in_h,
  input  logic              ssyn_in_h,
  output logic              br_out_h,
  output logic              sack_out_h,
  output logic              bbsy_out_h,
  output logic              intr_out_h,
  output logic              bg_out_h,
  output logic [15:0]       d_out_h,
  output logic              timeout_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = $clog2(DESKEW + 1) + 1;
  localparam int TW = $clog2(TMO + 1) + 1;

  localparam logic [DW-1:0] DESK_LAST = (DESKEW > 0) ? DW'(DESKEW - 1) : '0;
  localparam logic [TW-1:0] TMO_LAST  = (TMO > 0) ? TW'(TMO - 1) : '0;
  localparam logic [TW-1:0] TMO_SAT   = TW'(TMO);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_DESK = 3'd2,
    ST_SACK = 3'd3,
    ST_INTR = 3'd4,
    ST_REL  = 3'd5
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [7:0]      r_vec;
  logic [DW-1:0]   r_dcnt;
  logic [TW-1:0]   r_tcnt;
  logic            r_br;
  logic            r_sack;
  logic            r_bbsy;
  logic            r_intr;
  logic [15:0]     r_d;
  logic [NREQ-1:0] r_ack;
  logic            r_tmo;

  logic            w_any;
  logic [IW-1:0]   w_win_idx;
  logic [7:0]      w_win_vec;
  logic [NREQ-1:0] w_ack_onehot;
  logic            w_bus_idle;
  logic            w_desk_done;
  logic            w_tmo_done;

  assign w_any       = |irq_in;
  assign w_bus_idle  = !bg_in_h && !bbsy_in_h && !ssyn_in_h;
  assign w_desk_done = (r_dcnt >= DESK_LAST);
  assign w_tmo_done  = (r_tcnt >= TMO_LAST);

  // Lowest set index wins; scanning downward leaves the smallest index last.
  always_comb begin
    w_win_idx = '0;
    w_win_vec = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (irq_in[i]) begin
        w_win_idx = IW'(i);
        w_win_vec = vec_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_ack_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ack_onehot[i] = (r_idx == IW'(i));
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_vec   <= '0;
      r_dcnt  <= '0;
      r_tcnt  <= '0;
      r_br    <= 1'b0;
      r_sack  <= 1'b0;
      r_bbsy  <= 1'b0;
      r_intr  <= 1'b0;
      r_d     <= '0;
      r_ack   <= '0;
      r_tmo   <= 1'b0;
    end else if (init_in_h) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_vec   <= '0;
      r_dcnt  <= '0;
      r_tcnt  <= '0;
      r_br    <= 1'b0;
      r_sack  <= 1'b0;
      r_bbsy  <= 1'b0;
      r_intr  <= 1'b0;
      r_d     <= '0;
      r_ack   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_ack <= '0;
      r_tmo <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A grant already present belongs to a device further down the chain.
          if (w_any && !bg_in_h) begin
            r_state <= ST_REQ;
            r_br    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!w_any) begin
            r_state <= ST_IDLE;
            r_br    <= 1'b0;
          end else if (bg_in_h) begin
            r_state <= ST_DESK;
            r_idx   <= w_win_idx;
            r_vec   <= w_win_vec;
            r_dcnt  <= '0;
          end
        end
        ST_DESK: begin
          if (!bg_in_h) begin
            r_state <= ST_REQ;
            r_idx   <= '0;
            r_vec   <= '0;
            r_dcnt  <= '0;
          end else if (w_desk_done) begin
            r_state <= ST_SACK;
            r_br    <= 1'b0;
            r_sack  <= 1'b1;
            r_dcnt  <= r_dcnt + DW'(1);
          end else begin
            r_dcnt  <= r_dcnt + DW'(1);
          end
        end
        ST_SACK: begin
          if (w_bus_idle) begin
            r_state <= ST_INTR;
            r_sack  <= 1'b0;
            r_bbsy  <= 1'b1;
            r_intr  <= 1'b1;
            r_d     <= {8'h00, r_vec};
            r_tcnt  <= '0;
          end
        end
        ST_INTR: begin
          if (ssyn_in_h) begin
            r_state <= ST_REL;
            r_bbsy  <= 1'b0;
            r_intr  <= 1'b0;
            r_d     <= '0;
            r_ack   <= w_ack_onehot;
          end else if (w_tmo_done) begin
            r_state <= ST_REL;
            r_bbsy  <= 1'b0;
            r_intr  <= 1'b0;
            r_d     <= '0;
            r_tmo   <= 1'b1;
          end else if (r_tcnt < TMO_SAT) begin
            r_tcnt  <= r_tcnt + TW'(1);
          end
        end
        ST_REL: begin
          if (!ssyn_in_h) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_vec   <= '0;
            r_dcnt  <= '0;
            r_tcnt  <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_br    <= 1'b0;
          r_sack  <= 1'b0;
          r_bbsy  <= 1'b0;
          r_intr  <= 1'b0;
          r_d     <= '0;
        end
      endcase
    end
  end

  assign br_out_h    = r_br;
  assign sack_out_h  = r_sack;
  assign bbsy_out_h  = r_bbsy;
  assign intr_out_h  = r_intr;
  assign d_out_h     = r_d;
  assign irq_ack     = r_ack;
  assign timeout_out = r_tmo;
  assign bg_out_h    = (r_state == ST_IDLE) && bg_in_h;

endmodule

// File: tb/tb_intr_arb.sv
// Bench for intr_arb: directed bus sequences plus randomized arbitration rounds
// checked against a transaction-level model of winner, vector and handshake timing.
module tb_intr_arb;
  localparam int NREQ   = 4;
  localparam int DESKEW = 2;
  localparam int TMO    = 255;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic [NREQ-1:0]   irq_in;
  logic [8*NREQ-1:0] vec_in;
  logic [NREQ-1:0]   irq_ack;
  logic              init_in_h, bg_in_h, bbsy_in_h, ssyn_in_h;
  logic              br_out_h, sack_out_h, bbsy_out_h, intr_out_h, bg_out_h;
  logic [15:0]       d_out_h;
  logic              timeout_out;
  logic [NREQ+20:0]  outs;

  logic [7:0] vec_m [NREQ];
  int n_tests = 0;
  int n_fail  = 0;

  intr_arb #(.NREQ(NREQ), .DESKEW(DESKEW), .TMO(TMO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .irq_in(irq_in), .vec_in(vec_in), .irq_ack(irq_ack),
    .init_in_h(init_in_h), .bg_in_h(bg_in_h), .bbsy_in_h(bbsy_in_h), .ssyn_in_h(ssyn_in_h),
    .br_out_h(br_out_h), .sack_out_h(sack_out_h), .bbsy_out_h(bbsy_out_h),
    .intr_out_h(intr_out_h), .bg_out_h(bg_out_h), .d_out_h(d_out_h), .timeout_out(timeout_out)
  );

  always #5 CLOCK = ~CLOCK;

  for (genvar g = 0; g < NREQ; g++) begin : g_vec
    assign vec_in[8*g +: 8] = vec_m[g];
  end

  assign outs = {br_out_h, sack_out_h, bbsy_out_h, intr_out_h, timeout_out, irq_ack, d_out_h};

  // Reference rules: lowest set bit wins; its one-hot is the expected ack.
  function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] irq);
    return irq & (~irq + 1'b1);
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] oh);
    int r = 0;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic tick();
    @(negedge CLOCK);
  endtask

  task automatic idle_inputs();
    irq_in = '0; bg_in_h = 1'b0; bbsy_in_h = 1'b0; ssyn_in_h = 1'b0; init_in_h = 1'b0;
  endtask

  task automatic rand_vecs();
    for (int i = 0; i < NREQ; i++) vec_m[i] = 8'($urandom);
  endtask

  // From IDLE: one edge to REQ, then DESKEW+1 edges of grant to reach SACK.
  task automatic reach_sack(input logic [NREQ-1:0] irq);
    irq_in = irq;
    tick();
    bg_in_h = 1'b1;
    repeat (DESKEW + 1) tick();
  endtask

  task automatic reach_intr(input logic [NREQ-1:0] irq);
    reach_sack(irq);
    bg_in_h = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rand_vecs();
    RESET = 1'b1;
    #3;
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outs got=%h exp=0", outs); end
    bg_in_h = 1'b1;
    #1;
    n_tests++;
    if (bg_out_h !== 1'b1) begin n_fail++; $display("FAIL reset_bg_pass got=%b exp=1", bg_out_h); end
    bg_in_h = 1'b0;
    irq_in = 4'b0001;
    repeat (2) tick();
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_held got=%h exp=0", outs); end
    irq_in = '0;
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    rand_vecs();
    vec_m[2] = 8'o064;
    irq_in = 4'b0100;
    tick();
    n_tests++;
    if ({br_out_h, sack_out_h} !== 2'b10) begin n_fail++; $display("FAIL basic_req br_sack=%b exp=10", {br_out_h, sack_out_h}); end
    bg_in_h = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({br_out_h, sack_out_h} !== 2'b10) begin n_fail++; $display("FAIL basic_desk br_sack=%b exp=10", {br_out_h, sack_out_h}); end
    tick();
    n_tests++;
    if ({br_out_h, sack_out_h} !== 2'b01) begin n_fail++; $display("FAIL basic_sack br_sack=%b exp=01", {br_out_h, sack_out_h}); end
    bg_in_h = 1'b0;
    tick();
    n_tests++;
    if ({intr_out_h, bbsy_out_h, sack_out_h, d_out_h} !== {3'b110, 16'o000064}) begin
      n_fail++; $display("FAIL basic_intr intr=%b bbsy=%b sack=%b d=%o exp 1 1 0 000064",
                         intr_out_h, bbsy_out_h, sack_out_h, d_out_h);
    end
    ssyn_in_h = 1'b1;
    tick();
    n_tests++;
    if ({irq_ack, intr_out_h, d_out_h} !== {4'b0100, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL basic_ack ack=%b intr=%b d=%h exp 0100 0 0", irq_ack, intr_out_h, d_out_h);
    end
    tick();
    n_tests++;
    if (irq_ack !== '0) begin n_fail++; $display("FAIL basic_ack_width ack=%b exp=0000", irq_ack); end
    irq_in = '0; ssyn_in_h = 1'b0;
    tick();
    bg_in_h = 1'b1;
    #1;
    n_tests++;
    if (bg_out_h !== 1'b1) begin n_fail++; $display("FAIL basic_back_idle bg_out=%b exp=1", bg_out_h); end
    bg_in_h = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    rand_vecs();
    reach_intr(4'b1010);
    n_tests++;
    if (d_out_h !== {8'h00, vec_m[1]}) begin n_fail++; $display("FAIL prio_vec got=%h exp=%h", d_out_h, {8'h00, vec_m[1]}); end
    ssyn_in_h = 1'b1;
    tick();
    n_tests++;
    if (irq_ack !== 4'b0010) begin n_fail++; $display("FAIL prio_ack got=%b exp=0010", irq_ack); end
    irq_in = '0; ssyn_in_h = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_deskew();
    for (int it = 0; it < 8; it++) begin
      int  len;
      bit  take;
      len = (it == 0) ? 1 : int'($urandom_range(1, DESKEW + 2));
      take = (len >= DESKEW + 1);
      rand_vecs();
      irq_in = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      tick();
      bg_in_h = 1'b1;
      for (int k = 1; k <= len; k++) begin
        tick();
        n_tests++;
        if ({br_out_h, sack_out_h} !== {k < DESKEW + 1, k >= DESKEW + 1}) begin
          n_fail++; $display("FAIL deskew_hold len=%0d k=%0d br_sack=%b", len, k, {br_out_h, sack_out_h});
        end
      end
      bg_in_h = 1'b0;
      tick();
      if (take) begin
        n_tests++;
        if (intr_out_h !== 1'b1) begin n_fail++; $display("FAIL deskew_take len=%0d intr=%b exp=1", len, intr_out_h); end
        ssyn_in_h = 1'b1;
        tick();
        irq_in = '0; ssyn_in_h = 1'b0;
        repeat (2) tick();
      end else begin
        n_tests++;
        if ({br_out_h, sack_out_h} !== 2'b10) begin
          n_fail++; $display("FAIL deskew_abort len=%0d br_sack=%b exp=10", len, {br_out_h, sack_out_h});
        end
        irq_in = '0;
        tick();
        n_tests++;
        if (br_out_h !== 1'b0) begin n_fail++; $display("FAIL deskew_drop br=%b exp=0", br_out_h); end
      end
    end
  endtask

  task automatic test_bg_passthrough();
    bg_in_h = 1'b1;
    #1;
    n_tests++;
    if (bg_out_h !== 1'b1) begin n_fail++; $display("FAIL pass_idle bg_out=%b exp=1", bg_out_h); end
    irq_in = 4'b0001;
    repeat (2) tick();
    n_tests++;
    if ({br_out_h, bg_out_h} !== 2'b01) begin n_fail++; $display("FAIL pass_downstream br_bgout=%b exp=01", {br_out_h, bg_out_h}); end
    bg_in_h = 1'b0;
    tick();
    bg_in_h = 1'b1;
    #1;
    n_tests++;
    if ({br_out_h, bg_out_h} !== 2'b10) begin n_fail++; $display("FAIL pass_blocked br_bgout=%b exp=10", {br_out_h, bg_out_h}); end
    bg_in_h = 1'b0;
    irq_in = '0;
    tick();
  endtask

  task automatic test_random_arb();
    for (int it = 0; it < 20; it++) begin
      logic [NREQ-1:0] irq, exp_ack;
      logic [7:0]      exp_vec;
      int              w, dly;
      rand_vecs();
      irq     = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      exp_ack = exp_grant(irq);
      exp_vec = vec_m[onehot_idx(exp_ack)];
      irq_in = irq;
      tick();
      bg_in_h = 1'b1;
      tick();
      // Winner is fixed now: later request and vector changes must not matter.
      irq_in = NREQ'($urandom);
      rand_vecs();
      repeat (DESKEW) tick();
      n_tests++;
      if (sack_out_h !== 1'b1) begin n_fail++; $display("FAIL rand_sack it=%0d sack=%b exp=1", it, sack_out_h); end
      bg_in_h = 1'b0;
      w = int'($urandom_range(0, 3));
      bbsy_in_h = (w > 0);
      for (int k = 0; k < w; k++) begin
        tick();
        n_tests++;
        if ({sack_out_h, intr_out_h} !== 2'b10) begin
          n_fail++; $display("FAIL rand_busy it=%0d sack_intr=%b exp=10", it, {sack_out_h, intr_out_h});
        end
      end
      bbsy_in_h = 1'b0;
      tick();
      n_tests++;
      if ({intr_out_h, bbsy_out_h, d_out_h} !== {2'b11, 8'h00, exp_vec}) begin
        n_fail++; $display("FAIL rand_vec it=%0d intr=%b bbsy=%b d=%h exp_d=%h", it, intr_out_h, bbsy_out_h, d_out_h, exp_vec);
      end
      dly = int'($urandom_range(0, 4));
      for (int k = 0; k < dly; k++) begin
        tick();
        n_tests++;
        if ({irq_ack, intr_out_h} !== {{NREQ{1'b0}}, 1'b1}) begin
          n_fail++; $display("FAIL rand_wait it=%0d ack=%b intr=%b exp 0 1", it, irq_ack, intr_out_h);
        end
      end
      ssyn_in_h = 1'b1;
      tick();
      n_tests++;
      if (irq_ack !== exp_ack) begin n_fail++; $display("FAIL rand_ack it=%0d got=%b exp=%b", it, irq_ack, exp_ack); end
      irq_in = '0;
      tick();
      n_tests++;
      if (irq_ack !== '0) begin n_fail++; $display("FAIL rand_ack_width it=%0d got=%b exp=0", it, irq_ack); end
      ssyn_in_h = 1'b0;
      repeat (2) tick();
    end
  endtask

  task automatic test_timeout();
    bit bad;
    rand_vecs();
    reach_intr(4'b1000);
    bad = 1'b0;
    repeat (TMO - 1) begin
      tick();
      if (timeout_out !== 1'b0 || intr_out_h !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL tmo_early_edge got=%b exp=0", bad); end
    ssyn_in_h = 1'b1;
    tick();
    n_tests++;
    if ({irq_ack, timeout_out} !== {4'b1000, 1'b0}) begin
      n_fail++; $display("FAIL tmo_last_ack ack=%b tmo=%b exp 1000 0", irq_ack, timeout_out);
    end
    irq_in = '0; ssyn_in_h = 1'b0;
    repeat (2) tick();

    reach_intr(4'b0110);
    bad = 1'b0;
    repeat (TMO - 1) begin
      tick();
      if (timeout_out !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL tmo_early got=%b exp=0", bad); end
    irq_in = '0;
    tick();
    n_tests++;
    if ({timeout_out, irq_ack, intr_out_h, d_out_h} !== {1'b1, 4'b0000, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL tmo_pulse tmo=%b ack=%b intr=%b d=%h exp 1 0 0 0", timeout_out, irq_ack, intr_out_h, d_out_h);
    end
    tick();
    bg_in_h = 1'b1;
    #1;
    n_tests++;
    if ({timeout_out, bg_out_h} !== 2'b01) begin n_fail++; $display("FAIL tmo_to_idle tmo_bgout=%b exp=01", {timeout_out, bg_out_h}); end
    bg_in_h = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    rand_vecs();
    reach_intr(4'b0001);
    n_tests++;
    if (intr_out_h !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre intr=%b exp=1", intr_out_h); end
    #2 RESET = 1'b1;
    #1;
    n_tests++;
    if ({intr_out_h, bbsy_out_h} !== 2'b00) begin n_fail++; $display("FAIL rstmid_async intr_bbsy=%b exp=00", {intr_out_h, bbsy_out_h}); end
    ssyn_in_h = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL rstmid_noack got=%h exp=0", outs); end
    RESET = 1'b0; ssyn_in_h = 1'b0; irq_in = '0;
    tick();
  endtask

  task automatic test_init();
    rand_vecs();
    reach_sack(4'b0011);
    n_tests++;
    if (sack_out_h !== 1'b1) begin n_fail++; $display("FAIL init_pre sack=%b exp=1", sack_out_h); end
    init_in_h = 1'b1;
    tick();
    n_tests++;
    if ({outs, bg_out_h} !== {{(NREQ+21){1'b0}}, 1'b1}) begin
      n_fail++; $display("FAIL init_sack outs=%h bg_out=%b exp 0 1", outs, bg_out_h);
    end
    init_in_h = 1'b0; bg_in_h = 1'b0; irq_in = '0;
    tick();
    reach_intr(4'b0100);
    ssyn_in_h = 1'b1; init_in_h = 1'b1;
    tick();
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL init_cancel_ack got=%h exp=0", outs); end
    init_in_h = 1'b0; ssyn_in_h = 1'b0; irq_in = '0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_deskew();
    test_bg_passthrough();
    test_random_arb();
    test_timeout();
    test_reset_mid();
    test_init();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
